// File: rtl/mem_access_engine_pkg.sv
// Shared definitions for the block memory access engine: op encodings,
// FSM state encoding and default geometry.
package mem_access_engine_pkg;

  localparam int DEPTH_DEFAULT = 32;
  localparam int LEN_W_DEFAULT = 6;

  localparam logic [1:0] OP_COPY = 2'd0;
  localparam logic [1:0] OP_FILL = 2'd1;
  localparam logic [1:0] OP_SUM  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FL   = 3'd3,
    ST_SM   = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_range_check.sv
// Combinational command validation: rejects the reserved op and any region
// that would run past the end of memory. Sums are 33 bits so they cannot wrap.
module mem_access_range_check
  import mem_access_engine_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic [1:0]       op,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  output logic             error
);

  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic [32:0] limit;
  logic        uses_src;
  logic        uses_dst;

  always_comb begin
    src_end  = {1'b0, src_addr} + 33'(length);
    dst_end  = {1'b0, dst_addr} + 33'(length);
    limit    = 33'(DEPTH);
    uses_src = (op == OP_COPY) || (op == OP_SUM);
    uses_dst = (op == OP_COPY) || (op == OP_FILL);
    error    = (op == OP_RSVD)
            || (uses_src && (src_end > limit))
            || (uses_dst && (dst_end > limit));
  end

endmodule

// File: rtl/mem_access_engine.sv
// Block COPY / FILL / SUM engine driving a single-port word memory with
// clocked write and combinational read. One command in flight at a time.
module mem_access_engine
  import mem_access_engine_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      sum,
  output logic [31:0]      mem_address,
  output logic             mem_write_en,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic [2:0]       state_dbg
);

  // Handshake: start is a level sampled only in IDLE; the edge that sees it
  // accepts the command and raises busy. busy stays high through the single
  // done cycle; start while busy (including DONE) is dropped, never queued.

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [31:0]        fill_q, fill_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        sum_q, sum_d;
  logic               err_q, err_d;

  logic               range_err;
  logic               last;
  logic [LEN_W-1:0]   idx_inc;
  logic [31:0]        src_ptr;
  logic [31:0]        dst_ptr;

  mem_access_range_check #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W)
  ) u_range_check (
    .op       (op),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .error    (range_err)
  );

  always_comb begin
    idx_inc = idx_q + LEN_W'(1);
    last    = ({1'b0, idx_q} + (LEN_W+1)'(1)) == {1'b0, len_q};
    src_ptr = src_q + 32'(idx_q);
    dst_ptr = dst_q + 32'(idx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    data_d  = data_q;
    sum_d   = sum_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d  = length;
          src_d  = src_addr;
          dst_d  = dst_addr;
          fill_d = fill_value;
          idx_d  = '0;
          sum_d  = '0;
          err_d  = range_err;
          if (range_err || (length == '0)) begin
            state_d = ST_DONE;
          end else begin
            case (op)
              OP_COPY: state_d = ST_RD;
              OP_FILL: state_d = ST_FL;
              default: state_d = ST_SM;
            endcase
          end
        end
      end
      ST_RD: begin
        data_d  = mem_read_data;
        state_d = ST_WR;
      end
      ST_WR: begin
        idx_d   = idx_inc;
        state_d = last ? ST_DONE : ST_RD;
      end
      ST_FL: begin
        idx_d   = idx_inc;
        state_d = last ? ST_DONE : ST_FL;
      end
      ST_SM: begin
        sum_d   = sum_q + mem_read_data;
        idx_d   = idx_inc;
        state_d = last ? ST_DONE : ST_SM;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  // Memory port is a pure decode of state and registered pointers.
  always_comb begin
    mem_address    = '0;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    case (state_q)
      ST_RD, ST_SM: begin
        mem_address = src_ptr;
      end
      ST_WR: begin
        mem_address    = dst_ptr;
        mem_write_en   = 1'b1;
        mem_write_data = data_q;
      end
      ST_FL: begin
        mem_address    = dst_ptr;
        mem_write_en   = 1'b1;
        mem_write_data = fill_q;
      end
      default: begin
        mem_address = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    error     = done && err_q;
    sum       = sum_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mem_access_engine.sv
// Directed self-checking bench for mem_access_engine with a 32-word
// behavioural memory (clocked write, combinational read).
module tb_mem_access_engine;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [5:0]  length;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] sum;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [2:0]  state_dbg;

  logic [31:0] mem [32];
  logic        bd_we;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;
  int          wr_count = 0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  mem_access_engine dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .fill_value     (fill_value),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .sum            (sum),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model with a backdoor preload port
  assign mem_read_data = (mem_address < 32'd32) ? mem[mem_address[4:0]] : 32'h0;

  always @(posedge clock) begin
    if (mem_write_en) begin
      if (mem_address < 32'd32) mem[mem_address[4:0]] <= mem_write_data;
      wr_count <= wr_count + 1;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic poke(input int addr, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_addr = 5'(addr);
    bd_data = data;
    @(posedge clock); #1;
    bd_we   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] o, input int s, input int d, input int n, input logic [31:0] f);
    op         = o;
    src_addr   = 32'(s);
    dst_addr   = 32'(d);
    length     = 6'(n);
    fill_value = f;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
  endtask

  // Returns the cycle (1 = cycle after the accepting edge) in which done is high.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic run_cmd(input logic [1:0] o, input int s, input int d, input int n,
                         input logic [31:0] f, output int lat, output logic err, output int writes);
    int w0;
    w0 = wr_count;
    issue(o, s, d, n, f);
    wait_done(lat);
    err    = error;
    writes = wr_count - w0;
    @(posedge clock); #1;
  endtask

  // scoreboard: compare memory words against the expected queue
  task automatic check_mem(input string tag, input int base);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s[%0d]", tag, base + k), mem[base + k], exp_q.pop_front());
      k++;
    end
  endtask

  initial begin
    int          lat;
    logic        err;
    int          writes;
    int          w0;

    reset = 1'b1; start = 1'b0; op = '0; src_addr = '0; dst_addr = '0;
    length = '0; fill_value = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(mem_write_en), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_wdata", mem_write_data, 32'd0);
    check("rst_sum", sum, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) poke(i, 32'h1000_0000 + 32'(i));
    poke(0, 32'd11); poke(1, 32'd22); poke(2, 32'd33); poke(3, 32'd44);

    // COPY 0..3 -> 8..11
    run_cmd(2'd0, 0, 8, 4, 32'h0, lat, err, writes);
    check("copy_lat", 32'(lat), 32'd9);
    check("copy_err", 32'(err), 32'd0);
    check("copy_writes", 32'(writes), 32'd4);
    exp_q.push_back(32'd11); exp_q.push_back(32'd22);
    exp_q.push_back(32'd33); exp_q.push_back(32'd44);
    check_mem("copy_mem", 8);
    check("copy_idle", 32'(busy), 32'd0);

    // FILL 20..22
    run_cmd(2'd1, 0, 20, 3, 32'hDEADBEEF, lat, err, writes);
    check("fill_lat", 32'(lat), 32'd4);
    check("fill_err", 32'(err), 32'd0);
    check("fill_writes", 32'(writes), 32'd3);
    repeat (3) exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h1000_0017);
    check_mem("fill_mem", 20);

    // SUM with wrap-around
    poke(0, 32'hFFFF_FFFF); poke(1, 32'd2);
    run_cmd(2'd2, 0, 0, 2, 32'h0, lat, err, writes);
    check("sum_lat", 32'(lat), 32'd3);
    check("sum_err", 32'(err), 32'd0);
    check("sum_writes", 32'(writes), 32'd0);
    check("sum_val", sum, 32'd1);

    // bad commands and zero length
    run_cmd(2'd0, 30, 0, 4, 32'h0, lat, err, writes);
    check("bad_copy_lat", 32'(lat), 32'd1);
    check("bad_copy_err", 32'(err), 32'd1);
    check("bad_copy_writes", 32'(writes), 32'd0);
    check("bad_copy_sum_cleared", sum, 32'd0);
    run_cmd(2'd1, 0, 31, 2, 32'h5, lat, err, writes);
    check("bad_fill_lat", 32'(lat), 32'd1);
    check("bad_fill_err", 32'(err), 32'd1);
    check("bad_fill_writes", 32'(writes), 32'd0);
    check("bad_fill_w31", mem[31], 32'h1000_001F);
    run_cmd(2'd3, 0, 0, 1, 32'h0, lat, err, writes);
    check("bad_op_lat", 32'(lat), 32'd1);
    check("bad_op_err", 32'(err), 32'd1);
    check("bad_op_writes", 32'(writes), 32'd0);
    run_cmd(2'd0, 0, 8, 0, 32'h0, lat, err, writes);
    check("zero_len_lat", 32'(lat), 32'd1);
    check("zero_len_err", 32'(err), 32'd0);
    check("zero_len_writes", 32'(writes), 32'd0);
    run_cmd(2'd1, 0, 28, 4, 32'h77, lat, err, writes);
    check("edge_fill_err", 32'(err), 32'd0);
    check("edge_fill_writes", 32'(writes), 32'd4);
    check("edge_fill_w31", mem[31], 32'h77);

    // reset during the third WR of a 4-word COPY
    poke(0, 32'hA0); poke(1, 32'hA1); poke(2, 32'hA2); poke(3, 32'hA3);
    for (int i = 8; i < 12; i++) poke(i, 32'h0);
    w0 = wr_count;
    issue(2'd0, 0, 8, 4, 32'h0);
    repeat (5) begin @(posedge clock); #1; end
    check("abort_in_wr", 32'(mem_write_en), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (4) begin @(posedge clock); #1; end
    check("abort_writes", 32'(wr_count - w0), 32'd3);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2); exp_q.push_back(32'h0);
    check_mem("abort_mem", 8);

    // start while busy (and in DONE) is ignored
    issue(2'd0, 0, 16, 2, 32'h0);
    op = 2'd1; src_addr = 32'd0; dst_addr = 32'd24; length = 6'd1;
    fill_value = 32'h5; start = 1'b1;
    wait_done(lat);
    check("busy_start_lat", 32'(lat), 32'd5);
    check("busy_start_err", 32'(error), 32'd0);
    @(posedge clock); #1;
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    check_mem("busy_copy_mem", 16);
    check("busy_w24_untouched", mem[24], 32'h1000_0018);
    run_cmd(2'd1, 0, 24, 1, 32'h5, lat, err, writes);
    check("after_fill_lat", 32'(lat), 32'd2);
    check("after_fill_w24", mem[24], 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_engine.md
Name: mem_access_engine

Overview:
- Bus initiator that drives the single-port, word-addressed data memory: clocked write, combinational read.
- Executes one block command at a time: COPY (memory to memory), FILL (constant to memory) or SUM (read and accumulate).
- Sits between the control logic and the data memory port. Removes word-by-word load/store sequencing from the datapath.

Parameters:
- DEPTH, 32, number of memory words; used for the bounds check.
- LEN_W, 6, width of the length field (must hold DEPTH).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  2  0=COPY, 1=FILL, 2=SUM, 3=reserved.
- src_addr  input  32  source word address (COPY, SUM).
- dst_addr  input  32  destination word address (COPY, FILL).
- length  input  LEN_W  number of words.
- fill_value  input  32  constant written by FILL.
- busy  output  1  high from the accepting edge until DONE is left.
- done  output  1  one-cycle pulse at command end.
- error  output  1  valid only while done=1; set for bad op or out-of-range command.
- sum  output  32  SUM result modulo 2^32; holds until the next accepted command.
- mem_address  output  32  word address to memory.
- mem_write_en  output  1  memory write enable.
- mem_write_data  output  32  memory write data.
- mem_read_data  input  32  combinational read data from memory.

Behaviour:
- States: IDLE, RD, WR, FL, SM, DONE.
- Reset: on a reset edge the state goes to IDLE; counters, data register, sum and error are cleared. During IDLE and reset: busy=0, done=0, error=0, mem_write_en=0, mem_address=0, mem_write_data=0. Reset mid-command aborts at that edge; no further writes occur, and a partially written destination is left as is.
- Memory outputs are decoded combinationally from state and the registered counters. mem_write_en=1 only in WR and FL.
- Command acceptance (IDLE with start=1):
  - Latch all inputs. Clear index i and sum. Set busy.
  - Check at the same edge. Error if op=3, if src_addr+length > DEPTH (COPY/SUM), or if dst_addr+length > DEPTH (COPY/FILL). Compute in 33 bits so no wrap is possible.
  - On error, or if length=0: go to DONE with no memory access (error=0 for length 0).
  - Otherwise go to RD (COPY), FL (FILL) or SM (SUM).
- start outside IDLE is ignored; it is not queued.
- RD: mem_address=src+i. At the edge, mem_read_data is captured into the data register and the state goes to WR.
- WR: mem_address=dst+i, mem_write_data=data register, mem_write_en=1. At the edge, i increments; go to DONE if i+1==length, else RD.
- FL: mem_address=dst+i, mem_write_data=fill_value, mem_write_en=1. Increment i and finish as in WR.
- SM: mem_address=src+i. At the edge, sum<=sum+mem_read_data with wrap-around. Increment i and finish as in WR.
- DONE: done=1, busy=1, error=latched result. Go to IDLE at the next edge. A start in DONE is ignored.
- Latency from the accepting edge to done high:
  - COPY: 2N+1 cycles.
  - FILL and SUM: N+1 cycles.
  - Zero length or error: 1 cycle.
- Copy order is strictly ascending. Overlapping regions with dst>src therefore propagate data forward; this is the defined behaviour.

Decomposition:
- Shared package holds the op encodings (OP_COPY, OP_FILL, OP_SUM), the state enum and the DEPTH default.
- One sub-module is natural: mem_access_range_check. It is combinational: (op, src, dst, length) in, error out.
- The FSM, counters and the memory port stay in mem_access_engine.

Test Plan:
- Memory words 0..3 = 11,22,33,44; COPY src=0 dst=8 len=4 -> words 8..11 = 11,22,33,44; done in cycle 9 after acceptance; error=0; exactly 4 write cycles.
- FILL dst=20 len=3 value=DEADBEEF -> words 20..22 = DEADBEEF; word 23 unchanged; done after 4 cycles.
- SUM src=0 len=2 with words FFFFFFFF and 2 -> sum=1 (wrap); done after 3 cycles; no write cycles.
- Bad commands: COPY src=30 len=4; FILL dst=31 len=2; op=3 -> each gives done with error=1 one cycle after acceptance and no mem_write_en. length=0 -> done, error=0.
- Reset asserted in the 3rd WR of a 4-word COPY -> next cycle IDLE, busy=0, no 4th write, words 8..10 already written.
- start pulsed while busy with different operands -> ignored; the original command completes with its values; a new start after done is accepted.
